// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared FSM state type and default geometry for the data memory arbiter.
package data_mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;
   localparam int DEPTH_DEF  = 8;
endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; i_last names the requester served most recently.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);
   assign o_gnt[0] = i_req[0] & (~i_req[1] | i_last);
   assign o_gnt[1] = i_req[1] & (~i_req[0] | ~i_last);
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one combinational-read data memory between two requesters,
// one transaction at a time (grant, access, response).
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_err,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_err,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);
   state_t              r_state, w_next;
   logic                r_last, r_sel, r_we, r_err;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata, r_rdata;
   logic [1:0]          w_arb;
   logic                w_take, w_oor, w_acc, w_resp;

   rr_arb2 u_arb (
      .i_req  ({r1_req, r0_req}),
      .i_last (r_last),
      .o_gnt  (w_arb)
   );

   assign w_oor = r_addr >= ADDR_W'(DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // r_last resets to r1 so that r0 wins the first contended grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last  <= 1'b1;
         r_sel   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_take) begin
            r_sel   <= w_arb[1];
            r_we    <= w_arb[1] ? r1_we : r0_we;
            r_addr  <= w_arb[1] ? r1_addr : r0_addr;
            r_wdata <= w_arb[1] ? r1_wdata : r0_wdata;
         end
         if (r_state == ACCESS) begin
            r_err   <= w_oor;
            r_rdata <= (r_we || w_oor) ? '0 : mem_read_data;
         end
         if (r_state == RESP) r_last <= r_sel;
      end
   end

   // rst_n gating keeps every output quiet the instant reset asserts
   always_comb begin
      w_take          = rst_n && (r_state == IDLE) && (|w_arb);
      w_acc           = rst_n && (r_state == ACCESS) && !w_oor;
      w_resp          = rst_n && (r_state == RESP);
      w_next          = (r_state == IDLE) ? (w_take ? ACCESS : IDLE) :
                        (r_state == ACCESS) ? RESP : IDLE;
      r0_gnt          = w_take & ~w_arb[1];
      r1_gnt          = w_take & w_arb[1];
      mem_access_addr = w_acc ? r_addr : '0;
      mem_write_data  = w_acc ? r_wdata : '0;
      mem_write_en    = w_acc & r_we;
      mem_read        = w_acc & ~r_we;
      r0_rvalid       = w_resp & ~r_sel;
      r1_rvalid       = w_resp & r_sel;
      r0_rdata        = r0_rvalid ? r_rdata : '0;
      r1_rdata        = r1_rvalid ? r_rdata : '0;
      r0_err          = r0_rvalid & r_err;
      r1_err          = r1_rvalid & r_err;
   end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios against a bench-side memory, with a
// scoreboard of expected responses popped as rvalid pulses appear.
module tb_data_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [63:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
   logic [63:0] r0_rdata, r1_rdata;
   logic [63:0] mem_access_addr, mem_write_data, mem_read_data;
   logic        mem_write_en, mem_read;
   logic [63:0] mem [8];
   logic [63:0] ref_mem [8];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic        who;
      logic [63:0] data;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sb[$];
   exp_t me;

   data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
      .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
      .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
   assign mem_read_data = mem[mem_access_addr[2:0]];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("onehot", 64'({r0_gnt & r1_gnt, r0_rvalid & r1_rvalid}), 64'd0);
         chk("idle_resp_zero", 64'({r0_rvalid | (r0_rdata == 0 && !r0_err),
                                    r1_rvalid | (r1_rdata == 0 && !r1_err)}), 64'd3);
         if (r0_rvalid || r1_rvalid) begin
            chk("rvalid_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               me = sb.pop_front();
               chk("rvalid_who", 64'(r1_rvalid), 64'(me.who));
               chk("rdata", me.who ? r1_rdata : r0_rdata, me.data);
               chk("err", 64'(me.who ? r1_err : r0_err), 64'(me.err));
               chk("latency", 64'(cyc - me.cyc), 64'd2);
            end
         end
      end
   end

   task automatic issue(input logic who, input logic we, input logic [63:0] addr,
                        input logic [63:0] wd, input bit abort);
      exp_t e;
      int   n;
      logic rng, g;
      rng = addr < 64'd8;
      @(posedge clk); #1;
      if (who) begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wd; end
      else     begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wd; end
      n = 0; g = 0;
      while (!g && n < 20) begin
         @(negedge clk);
         n++;
         g = who ? r1_gnt : r0_gnt;
      end
      chk("gnt", 64'(g), 64'd1);
      if (!g) begin r0_req = 0; r1_req = 0; return; end
      chk("gnt_other", 64'(who ? r0_gnt : r1_gnt), 64'd0);
      chk("mem_idle", 64'({mem_write_en, mem_read}), 64'd0);
      if (!abort) begin
         e.who = who; e.data = (!we && rng) ? ref_mem[addr[2:0]] : '0;
         e.err = !rng; e.cyc = cyc;
         sb.push_back(e);
         if (we && rng) ref_mem[addr[2:0]] = wd;
      end
      @(posedge clk); #1;
      r0_req = 0; r1_req = 0;
      if (abort) begin
         chk("we_access", 64'(mem_write_en), 64'd1);
         #1 rst_n = 0;
         #1 chk("we_reset_drop", 64'(mem_write_en), 64'd0);
         return;
      end
      @(negedge clk);
      chk("access_we", 64'(mem_write_en), 64'(we && rng));
      chk("access_rd", 64'(mem_read), 64'(!we && rng));
      if (rng) chk("access_addr", mem_access_addr, addr);
      if (rng && we) chk("access_wdata", mem_write_data, wd);
      @(negedge clk);
      chk("mem_resp", 64'({mem_write_en, mem_read}), 64'd0);
      n = 0;
      while (sb.size() != 0 && n < 10) begin @(negedge clk); n++; end
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, prev;
      exp_t e;
      rst_n = 0;
      r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
      r1_req = 1; r1_we = 1; r1_addr = 64'd4; r1_wdata = 64'h77;
      @(negedge clk);
      @(negedge clk);
      chk("rst_gnt", 64'({r0_gnt, r1_gnt}), 64'd0);
      chk("rst_mem", 64'({mem_write_en, mem_read}), 64'd0);
      chk("rst_rvalid", 64'({r0_rvalid, r1_rvalid, r0_err, r1_err}), 64'd0);
      chk("rst_rdata", r0_rdata | r1_rdata | mem_access_addr, 64'd0);
      r1_req = 0;
      rst_n = 1;
      issue(0, 1, 64'd3, 64'hA5A5, 0);
      issue(0, 0, 64'd3, 64'h0, 0);
      issue(1, 1, 64'd0, 64'h0BAD, 0);
      issue(1, 1, 64'd1, 64'h1111, 0);
      issue(0, 1, 64'd2, 64'h2222, 0);
      issue(1, 1, 64'd6, 64'h6666, 0);
      issue(0, 1, 64'd5, 64'h5555, 0);
      issue(1, 1, 64'd8, 64'hFF, 0);
      chk("word0_kept", mem[0], 64'h0BAD);
      issue(1, 0, 64'd8, 64'h0, 0);
      issue(0, 0, 64'h8000_0000_0000_0002, 64'h0, 0);
      issue(0, 0, 64'd1, 64'h0, 0);
      issue(1, 0, 64'd6, 64'h0, 0);
      issue(0, 1, 64'd5, 64'hDEAD, 1);
      r0_req = 1; r0_we = 0; r0_addr = 64'd2;
      r1_req = 1; r1_we = 0; r1_addr = 64'd6;
      @(negedge clk);
      chk("rst_mid_gnt", 64'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}), 64'd0);
      @(negedge clk);
      chk("word5_kept", mem[5], 64'h5555);
      rst_n = 1;
      #1;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(r0_gnt || r1_gnt) && n < 10) begin @(negedge clk); n++; end
         chk("alt_gnt", 64'({r1_gnt, r0_gnt}), i[0] ? 64'd2 : 64'd1);
         if (i > 0) chk("alt_space", 64'(cyc - prev), 64'd3);
         prev = cyc;
         e.who = i[0]; e.data = ref_mem[i[0] ? 6 : 2]; e.err = 0; e.cyc = cyc;
         sb.push_back(e);
         if (i == 3) begin @(posedge clk); #1 r0_req = 0; r1_req = 0; end
         @(negedge clk);
      end
      n = 0;
      while (sb.size() != 0 && n < 10) begin @(negedge clk); n++; end
      chk("final_drain", 64'(sb.size()), 64'd0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 64, requester and memory address width.
REQ-002 Parameter DATA_W, 64, data width.
REQ-003 Parameter DEPTH, 8, number of memory words; addresses 0..DEPTH-1 are valid.
REQ-004 clk  in  1  single clock, all state rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rN_req  in  1  requester N (N=0,1) access request, held until rN_gnt.
REQ-007 rN_we  in  1  requester N: 1 = write, 0 = read.
REQ-008 rN_addr  in  ADDR_W  requester N word address.
REQ-009 rN_wdata  in  DATA_W  requester N write data.
REQ-010 rN_gnt  out  1  one-cycle pulse: requester N accepted.
REQ-011 rN_rvalid  out  1  one-cycle pulse: requester N transaction complete.
REQ-012 rN_rdata  out  DATA_W  read data, valid with rN_rvalid.
REQ-013 rN_err  out  1  out-of-range flag, valid with rN_rvalid.
REQ-014 mem_access_addr  out  ADDR_W  to data memory.
REQ-015 mem_write_data  out  DATA_W  to data memory.
REQ-016 mem_write_en  out  1  to data memory (memory writes on rising clk).
REQ-017 mem_read  out  1  to data memory.
REQ-018 mem_read_data  in  DATA_W  combinational memory read data.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any req, ACCESS->RESP always, RESP->IDLE always.
REQ-020 In IDLE with a request present, the block SHALL select one requester, pulse its rN_gnt that cycle, and latch its we, addr, wdata.
REQ-021 Selection SHALL be round-robin: when both request, the requester not served last wins; single request wins unconditionally.
REQ-022 The last-served pointer SHALL update in RESP to the requester just served.
REQ-023 In ACCESS, with latched addr < DEPTH, the block SHALL drive mem_access_addr = latched addr, mem_write_data = latched wdata, mem_write_en = we, mem_read = !we.
REQ-024 In ACCESS, with latched addr >= DEPTH (any of addr[ADDR_W-1:log2(DEPTH)] set), mem_write_en and mem_read SHALL both be 0 and an error SHALL be latched.
REQ-025 At the end of ACCESS the block SHALL register mem_read_data for reads, and 0 for writes or errors.
REQ-026 In RESP the served requester SHALL see rN_rvalid=1, rN_rdata = registered data, rN_err = latched error, all for exactly one cycle.
REQ-027 Latency: gnt in cycle T, memory access in T+1, rvalid in T+2; next gnt no earlier than T+3.
REQ-028 In IDLE and RESP all mem_* outputs SHALL be 0.
REQ-029 rN_rdata and rN_err SHALL be 0 whenever rN_rvalid is 0.
REQ-030 Deassertion of rN_req after gnt SHALL NOT affect the accepted transaction.
REQ-031 Requests arriving in ACCESS or RESP SHALL wait; no gnt outside IDLE.
REQ-032 At most one rN_gnt and one rN_rvalid SHALL be high in any cycle.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, all outputs 0, latched data 0, and the pointer to favour r0 first.
REQ-034 Reset asserted during ACCESS SHALL drop mem_write_en combinationally so no write occurs; the aborted transaction produces no rvalid.
REQ-035 The first rising clk after rst_n rises SHALL be able to grant.

Structure
REQ-036 Package data_mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP) and default ADDR_W, DATA_W, DEPTH constants.
REQ-037 The round-robin selection SHALL be sub-module rr_arb2 (2 requests, last-served pointer in, one-hot grant out).
REQ-038 Memory instance SHALL sit outside this block; the bench connects it.

Verification
REQ-039 r0 write addr 3 data 0xA5A5 then r0 read addr 3 -> gnt T, write_en high in T+1 only, later rvalid with rdata 0xA5A5, err 0.
REQ-040 r0 and r1 both request reads continuously after reset -> grants alternate r0, r1, r0, r1 at 3-cycle spacing.
REQ-041 r1 write addr 8 data 0xFF -> mem_write_en never high, r1_rvalid with err 1, rdata 0; memory word 0 unchanged.
REQ-042 rst_n pulsed low during ACCESS of a write to addr 5 -> mem_write_en drops at once, word 5 unchanged, no rvalid, next grant to r0.
REQ-043 r0_req dropped the cycle after gnt for read addr 1 -> rvalid still issued two cycles after gnt with word 1 contents.
